// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory FSM encoding, word width and the opcode field
// values the controller and memory unit agree on.
package cpu_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_BUSY = 2'd1;
  localparam logic [1:0] MEM_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MEM_IDLE,
    ST_BUSY = MEM_BUSY,
    ST_DONE = MEM_DONE
  } mem_state_e;

  // Operation latched by the memory unit when a request is accepted.
  typedef enum logic [1:0] {
    MOP_NONE  = 2'd0,
    MOP_READ  = 2'd1,
    MOP_WRITE = 2'd2
  } mem_op_e;

  // Opcode field of the instruction word, decoded by the controller.
  typedef enum logic [3:0] {
    OPC_NOP    = 4'h0,
    OPC_LOAD   = 4'h1,
    OPC_STORE  = 4'h2,
    OPC_ALU    = 4'h3,
    OPC_BRANCH = 4'h4,
    OPC_HALT   = 4'hF
  } opcode_e;

  // True while the requester still holds the strobe of the latched operation.
  function automatic logic strobe_held(mem_op_e op, logic rd, logic wr);
    return ((op == MOP_READ) && rd) || ((op == MOP_WRITE) && wr);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a one-cycle registered read. Storage is
// never reset; only the surrounding controller state is.
module mem_array
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write-first is not needed: reads and writes never target the same access.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_unit.sv
// Main-memory model with a read/write/MFC handshake. Requests are latched on
// acceptance, committed LATENCY edges later, and MFC is held until the
// requester releases its strobe.
module memory_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  MFC,
  output logic                  busy
);

  localparam int             CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e            state_q, state_d;
  mem_op_e               op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  mfc_q, mfc_d;
  logic                  busy_q, busy_d;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  held;

  generate
    if (ADDR_WIDTH < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[15:ADDR_WIDTH];
    end
  endgenerate

  // The RAM address comes straight from the port while idle so the registered
  // read is already valid one edge after acceptance; that way a read with
  // LATENCY=1 still has fresh data when MFC rises.
  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_array (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // Next-state logic for the IDLE/BUSY/DONE handshake and access commit.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    mfc_d    = mfc_q;
    busy_d   = busy_q;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    held     = strobe_held(op_q, read, write);

    unique case (state_q)
      ST_IDLE: begin
        ram_addr = address[ADDR_WIDTH-1:0];
        if (read ^ write) begin
          op_d    = read ? MOP_READ : MOP_WRITE;
          addr_d  = address[ADDR_WIDTH-1:0];
          wdata_d = dataIn;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
          busy_d  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!held) begin
          state_d = ST_IDLE;
          op_d    = MOP_NONE;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
          mfc_d   = 1'b1;
          if (op_q == MOP_WRITE) begin
            ram_we = 1'b1;
          end else begin
            dout_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!read && !write) begin
          state_d = ST_IDLE;
          op_d    = MOP_NONE;
          mfc_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        op_d    = MOP_NONE;
        mfc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A reset landing on the commit edge discards the pending write.
    ram_we = ram_we & ~reset;
  end

  // Control state is reset; latched address/data are don't-care until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= MOP_NONE;
      cnt_q   <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      busy_q  <= busy_d;
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign dataOut = dout_q;
  assign MFC     = mfc_q;
  assign busy    = busy_q;

endmodule
